sao_feeder: RTL and testbench
=============================

SAO_FEEDER -- requirements
Module: sao_feeder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports named clk and reset.
REQ-002 Parameter IMG_W, default 128, image width and height in pixels.
REQ-003 Parameter MAX_LCU, default 64, parameter-table depth.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 start  input  1  one-cycle pulse, begins a frame; ignored unless in IDLE.
REQ-007 cfg_lcu_size  input  2  frame LCU size, 0=16x16, 1=32x32, 2=64x64, 3=reserved; sampled with start.
REQ-008 img_rd / img_addr  output  1 / 14  pixel-memory read strobe and address (LCU-major order: each LCU's pixels contiguous, raster within the LCU).
REQ-009 img_data  input  8  pixel returned exactly one cycle after img_rd.
REQ-010 par_rd / par_addr  output  1 / 6  parameter-table read strobe and LCU index.
REQ-011 par_data  input  24  returned one cycle after par_rd; [23:22] type, [21:17] band_pos, [16] eo_class, [15:0] offset.
REQ-012 busy  input  1  SAO backpressure.
REQ-013 in_en, din[7:0], sao_type[1:0], sao_band_pos[4:0], sao_eo_class, sao_offset[15:0], lcu_x[2:0], lcu_y[2:0], lcu_size[1:0]  outputs  SAO input beat.
REQ-014 done  output  1  one-cycle pulse after the last beat is accepted.
REQ-015 cfg_err  output  1  one-cycle pulse when start arrives with cfg_lcu_size=3.

Function
REQ-016 A beat SHALL transfer on a rising edge where in_en=1 and busy=0; while in_en=1 and busy=1, all beat outputs SHALL hold stable.
REQ-017 FSM states: IDLE, PAR, PARW, PIX, DRAIN, FIN.
REQ-018 IDLE: start with valid size -> PAR, latching size into lcu_size and clearing pixel address and LCU index; start with size 3 -> pulse cfg_err, remain IDLE.
REQ-019 PAR: assert par_rd with par_addr=current LCU index for one cycle -> PARW.
REQ-020 PARW: capture par_data into sao_type/band_pos/eo_class/offset; lcu_x = idx mod (IMG_W/N), lcu_y = idx div (IMG_W/N), N = 16<<lcu_size -> PIX.
REQ-021 PIX: pixels pass through a 2-entry FIFO; img_rd SHALL assert only when FIFO occupancy plus outstanding reads < 2, so no returned pixel is ever dropped.
REQ-022 in_en SHALL equal FIFO not-empty; din SHALL be the FIFO head.
REQ-023 With busy held low, PIX SHALL sustain one beat per clock.
REQ-024 After issuing the last address of an LCU (N*N reads), go to DRAIN; no further img_rd.
REQ-025 DRAIN: wait for FIFO empty; then -> PAR for next LCU, or -> FIN after the last LCU ((IMG_W/N)^2 LCUs).
REQ-026 FIN: pulse done for one cycle -> IDLE.
REQ-027 Sideband outputs (sao_*, lcu_x, lcu_y) SHALL change only in PARW, i.e. never while any pixel of the previous LCU is still unaccepted.
REQ-028 img_addr SHALL increment by 1 per img_rd and end at IMG_W*IMG_W-1; LCU index SHALL increment by 1 per LCU.
REQ-029 Latency: start at edge T -> par_rd high cycle T+1, first img_rd cycle T+2, first in_en cycle T+3.
REQ-030 start outside IDLE SHALL be ignored; busy outside PIX/DRAIN has no effect.

Reset
REQ-031 reset SHALL return FSM to IDLE, clear FIFO and outstanding-read tracking, and drive in_en, img_rd, par_rd, done, cfg_err, din, sao_*, lcu_x, lcu_y, lcu_size, img_addr, par_addr to 0.
REQ-032 reset mid-frame SHALL abandon the frame; a read returning the cycle after reset SHALL be discarded.

Verification
REQ-033 size 0, busy=0, memory = address[7:0] -> 16384 beats, din sequence 00..FF repeated, 64 LCUs, lcu_x/lcu_y 0..7 raster, done after last beat.
REQ-034 size 2 -> 4 LCUs, lcu (x,y) = (0,0),(1,0),(0,1),(1,1), 4096 beats each, par_addr 0..3.
REQ-035 random busy (50%) -> exact beat sequence as REQ-033, no duplicate or missing pixel, outputs stable during busy.
REQ-036 par entry 1 = 24'b10_00101_1_0000000000000011 -> pixels 256..511 carry type 2, band 5, eo 1, offset 0x0003; pixel 255 still carries entry 0.
REQ-037 start with cfg_lcu_size=3 -> cfg_err pulse, no reads; reset at beat 1000 then start -> frame restarts at img_addr 0.

Source files
------------

// File: rtl/sao_feeder.sv
// sao_feeder: per-LCU front end for an SAO filter. For each LCU of a frame
// it reads one parameter-table entry, then streams that LCU's pixels from a
// one-cycle-latency pixel memory through a 2-entry FIFO to the SAO input.
//
// Beat handshake: in_en is valid and !busy is ready. A beat moves on a rising
// edge with in_en=1 and busy=0. While in_en=1 and busy=1, din, sao_*, lcu_x,
// lcu_y and lcu_size all hold their values.
module sao_feeder #(
  parameter int IMG_W   = 128,
  parameter int MAX_LCU = 64,
  localparam int AW     = $clog2(IMG_W * IMG_W),
  localparam int PW     = $clog2(MAX_LCU)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [1:0]    cfg_lcu_size,
  output logic          img_rd,
  output logic [AW-1:0] img_addr,
  input  logic [7:0]    img_data,
  output logic          par_rd,
  output logic [PW-1:0] par_addr,
  input  logic [23:0]   par_data,
  input  logic          busy,
  output logic          in_en,
  output logic [7:0]    din,
  output logic [1:0]    sao_type,
  output logic [4:0]    sao_band_pos,
  output logic          sao_eo_class,
  output logic [15:0]   sao_offset,
  output logic [2:0]    lcu_x,
  output logic [2:0]    lcu_y,
  output logic [1:0]    lcu_size,
  output logic          done,
  output logic          cfg_err,
  output logic [2:0]    dbg_state
);

  localparam int LW  = $clog2(IMG_W);
  // Per-LCU pixel counter: must reach 64*64 for the largest LCU.
  localparam int PCW = 13;

  localparam logic [PW-1:0]  ONE_P = PW'(1);
  localparam logic [AW-1:0]  ONE_A = AW'(1);
  localparam logic [PCW-1:0] ONE_C = PCW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PAR   = 3'd1,
    S_PARW  = 3'd2,
    S_PIX   = 3'd3,
    S_DRAIN = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [AW-1:0]  r_img_addr;
  logic [PW-1:0]  r_lcu_idx;
  logic [PCW-1:0] r_pix_cnt;
  logic [1:0]     r_lcu_size;
  logic [1:0]     r_sao_type;
  logic [4:0]     r_band_pos;
  logic           r_eo_class;
  logic [15:0]    r_offset;
  logic [2:0]     r_lcu_x;
  logic [2:0]     r_lcu_y;
  logic           r_cfg_err;

  // FIFO storage and the "read returning this cycle" flag
  logic [7:0]     r_fifo_mem [2];
  logic           r_wptr;
  logic           r_rptr;
  logic [1:0]     r_cnt;
  logic           r_rd_pend;

  logic [2:0]     w_row_shift;
  logic [PW-1:0]  w_row_mask;
  logic [PW-1:0]  w_lcu_last;
  logic [PCW-1:0] w_pix_last;
  logic           w_fifo_ne;
  logic [7:0]     w_head;
  logic           w_pop;
  logic           w_bypass;
  logic           w_push;
  logic           w_deq;
  logic           w_room;

  // LCU geometry: log2(LCUs per row) = log2(IMG_W) - 4 - lcu_size
  assign w_row_shift = 3'(LW - 4) - {1'b0, r_lcu_size};
  assign w_row_mask  = (ONE_P << w_row_shift) - ONE_P;
  assign w_lcu_last  = (ONE_P << {w_row_shift, 1'b0}) - ONE_P;
  assign w_pix_last  = (ONE_C << (4'd8 + {1'b0, r_lcu_size, 1'b0})) - ONE_C;

  // FIFO is fall-through: a returning pixel is visible at the head the same
  // cycle it arrives, and is stored only if it cannot leave immediately.
  assign w_fifo_ne = (r_cnt != 2'd0) || r_rd_pend;
  assign w_head    = (r_cnt != 2'd0) ? r_fifo_mem[r_rptr] : img_data;
  assign w_pop     = w_fifo_ne && !busy;
  assign w_bypass  = (r_cnt == 2'd0) && r_rd_pend && w_pop;
  assign w_push    = r_rd_pend && !w_bypass;
  assign w_deq     = w_pop && (r_cnt != 2'd0);
  // A new read is allowed only if stored plus in-flight pixels leave a slot.
  assign w_room    = ({1'b0, r_cnt} + {2'b00, r_rd_pend}) < 3'd2;

  assign in_en        = w_fifo_ne;
  assign din          = w_fifo_ne ? w_head : 8'd0;
  assign img_addr     = r_img_addr;
  assign par_addr     = r_lcu_idx;
  assign sao_type     = r_sao_type;
  assign sao_band_pos = r_band_pos;
  assign sao_eo_class = r_eo_class;
  assign sao_offset   = r_offset;
  assign lcu_x        = r_lcu_x;
  assign lcu_y        = r_lcu_y;
  assign lcu_size     = r_lcu_size;
  assign cfg_err      = r_cfg_err;
  assign dbg_state    = r_state;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start && (cfg_lcu_size != 2'd3)) w_next = S_PAR;
      S_PAR:   w_next = S_PARW;
      S_PARW:  w_next = S_PIX;
      S_PIX:   if (img_rd && (r_pix_cnt == w_pix_last)) w_next = S_DRAIN;
      S_DRAIN: if (!w_fifo_ne) w_next = (r_lcu_idx == w_lcu_last) ? S_FIN : S_PAR;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Memory strobes and done pulse; the first pixel read overlaps PARW
  always_comb begin
    img_rd = 1'b0;
    par_rd = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_PAR:   par_rd = 1'b1;
      S_PARW:  img_rd = 1'b1;
      S_PIX:   img_rd = w_room;
      S_FIN:   done   = 1'b1;
      default: ;
    endcase
  end

  // Frame datapath: configuration, addresses, counters, LCU sideband
  always_ff @(posedge clk) begin
    if (reset) begin
      r_img_addr <= '0;
      r_lcu_idx  <= '0;
      r_pix_cnt  <= '0;
      r_lcu_size <= 2'd0;
      r_sao_type <= 2'd0;
      r_band_pos <= 5'd0;
      r_eo_class <= 1'b0;
      r_offset   <= 16'd0;
      r_lcu_x    <= 3'd0;
      r_lcu_y    <= 3'd0;
      r_cfg_err  <= 1'b0;
    end else begin
      r_cfg_err <= 1'b0;
      if ((r_state == S_IDLE) && start) begin
        if (cfg_lcu_size == 2'd3) begin
          r_cfg_err <= 1'b1;
        end else begin
          r_lcu_size <= cfg_lcu_size;
          r_img_addr <= '0;
          r_lcu_idx  <= '0;
        end
      end
      if (r_state == S_PAR) r_pix_cnt <= '0;
      // Sideband only changes here, after the previous LCU fully drained
      if (r_state == S_PARW) begin
        r_sao_type <= par_data[23:22];
        r_band_pos <= par_data[21:17];
        r_eo_class <= par_data[16];
        r_offset   <= par_data[15:0];
        r_lcu_x    <= 3'(r_lcu_idx & w_row_mask);
        r_lcu_y    <= 3'(r_lcu_idx >> w_row_shift);
      end
      if (img_rd) begin
        r_img_addr <= r_img_addr + ONE_A;
        r_pix_cnt  <= r_pix_cnt + ONE_C;
      end
      if ((r_state == S_DRAIN) && !w_fifo_ne && (r_lcu_idx != w_lcu_last))
        r_lcu_idx <= r_lcu_idx + ONE_P;
    end
  end

  // Pixel FIFO and in-flight read tracking; reset drops any returning read
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fifo_mem[0] <= 8'd0;
      r_fifo_mem[1] <= 8'd0;
      r_wptr        <= 1'b0;
      r_rptr        <= 1'b0;
      r_cnt         <= 2'd0;
      r_rd_pend     <= 1'b0;
    end else begin
      r_rd_pend <= img_rd;
      if (w_push) begin
        r_fifo_mem[r_wptr] <= img_data;
        r_wptr             <= ~r_wptr;
      end
      if (w_deq) r_rptr <= ~r_rptr;
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_deq};
    end
  end

endmodule

// File: tb/tb_sao_feeder.sv
// tb_sao_feeder: frame-level bench for sao_feeder. The expected beat stream
// of a frame is derived from the pixel memory contents and the parameter
// table (pixel i belongs to LCU i/(N*N)); a negedge monitor compares every
// accepted beat, every strobe address and output stability under busy.
module tb_sao_feeder;

  localparam int IMG_W = 128;
  localparam int NPIX  = IMG_W * IMG_W;
  localparam int BW    = 40;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  cfg_lcu_size;
  logic        img_rd;
  logic [13:0] img_addr;
  logic [7:0]  img_data = 8'd0;
  logic        par_rd;
  logic [5:0]  par_addr;
  logic [23:0] par_data = 24'd0;
  logic        busy;
  logic        in_en;
  logic [7:0]  din;
  logic [1:0]  sao_type;
  logic [4:0]  sao_band_pos;
  logic        sao_eo_class;
  logic [15:0] sao_offset;
  logic [2:0]  lcu_x;
  logic [2:0]  lcu_y;
  logic [1:0]  lcu_size;
  logic        done;
  logic        cfg_err;
  logic [2:0]  dbg_state;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  sao_feeder #(.IMG_W(IMG_W), .MAX_LCU(64)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_lcu_size(cfg_lcu_size),
    .img_rd(img_rd), .img_addr(img_addr), .img_data(img_data),
    .par_rd(par_rd), .par_addr(par_addr), .par_data(par_data),
    .busy(busy), .in_en(in_en), .din(din),
    .sao_type(sao_type), .sao_band_pos(sao_band_pos),
    .sao_eo_class(sao_eo_class), .sao_offset(sao_offset),
    .lcu_x(lcu_x), .lcu_y(lcu_y), .lcu_size(lcu_size),
    .done(done), .cfg_err(cfg_err), .dbg_state(dbg_state)
  );

  // Memories: pixel memory holds address[7:0], data one cycle after strobe
  logic [23:0] par_mem [64];
  always @(posedge clk) begin
    if (img_rd) img_data <= img_addr[7:0];
    if (par_rd) par_data <= par_mem[par_addr];
  end

  bit rand_busy = 1'b0;
  initial begin
    busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      busy = rand_busy ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // ---------------- scoreboard ----------------
  logic [BW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_beats, n_rd, n_par, n_done, n_cfg_err;
  bit mon_en = 1'b0;
  bit prev_hold = 1'b0;
  logic [BW-1:0] prev_beat, exp_b;
  logic [BW-1:0] cap_255, cap_256, cap_4096, cap_8192, cap_last;

  function automatic logic [BW-1:0] beat_now();
    return {din, sao_type, sao_band_pos, sao_eo_class, sao_offset, lcu_x, lcu_y, lcu_size};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every accepted beat, strobe address and busy-hold cycle
  always @(negedge clk) begin
    if (reset || !mon_en) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) check("hold_stable", {in_en, beat_now()}, {1'b1, prev_beat});
      if (in_en && !busy) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL extra_beat: beat %0d got din 0x%0h, expected no beat", n_beats, din);
        end else begin
          exp_b = exp_q.pop_front();
          check($sformatf("beat%0d", n_beats), beat_now(), exp_b);
        end
        if (n_beats == 255)      cap_255  = beat_now();
        if (n_beats == 256)      cap_256  = beat_now();
        if (n_beats == 4096)     cap_4096 = beat_now();
        if (n_beats == 8192)     cap_8192 = beat_now();
        if (n_beats == NPIX - 1) cap_last = beat_now();
        n_beats++;
      end
      prev_hold = in_en && busy;
      prev_beat = beat_now();
      if (img_rd) begin
        check("img_addr", {50'd0, img_addr}, n_rd);
        n_rd++;
      end
      if (par_rd) begin
        check("par_addr", {58'd0, par_addr}, n_par);
        n_par++;
      end
      if (done) begin
        check("done_after_last", exp_q.size(), 0);
        n_done++;
      end
      if (cfg_err) n_cfg_err++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    n_beats = 0; n_rd = 0; n_par = 0; n_done = 0; n_cfg_err = 0;
    exp_q.delete();
  endtask

  // Expected beats: pixel i has value i mod 256, LCU i/(N*N), raster LCUs
  task automatic load_model(input int size);
    int n, per, idx;
    logic [23:0] e;
    n   = 16 << size;
    per = IMG_W / n;
    for (int i = 0; i < NPIX; i++) begin
      idx = i / (n * n);
      e   = par_mem[idx];
      exp_q.push_back({8'(i % 256), e[23:22], e[21:17], e[16], e[15:0],
                       3'(idx % per), 3'(idx / per), 2'(size)});
    end
  endtask

  // Starts a frame and checks the start -> par_rd -> img_rd -> in_en latency
  task automatic start_frame(input int size);
    tick();
    clear_counts();
    load_model(size);
    cfg_lcu_size = 2'(size);
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("lat_par_rd", par_rd, 1);
    check("lat_img_rd_early", img_rd, 0);
    @(negedge clk);
    check("lat_img_rd", img_rd, 1);
    check("lat_in_en_early", in_en, 0);
    @(negedge clk);
    check("lat_in_en", in_en, 1);
  endtask

  task automatic finish_frame(input int budget, input int n_lcu);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!done && c < budget);
    check("frame_done_in_budget", (c < budget), 1);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    repeat (3) @(negedge clk);
    check("frame_beats", n_beats, NPIX);
    check("frame_reads", n_rd, NPIX);
    check("frame_par_reads", n_par, n_lcu);
    check("frame_done_count", n_done, 1);
    check("frame_queue_empty", exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c;
    reset = 1'b1;
    start = 1'b0;
    cfg_lcu_size = 2'd0;
    for (int i = 0; i < 64; i++) par_mem[i] = 24'((i * 24'h02a5c3) ^ 24'h13579b);
    par_mem[0] = 24'b01_00011_0_0000000000100000;
    par_mem[1] = 24'b10_00101_1_0000000000000011;

    repeat (3) tick();
    @(negedge clk);
    check("rst_in_en", in_en, 0);
    check("rst_img_rd", img_rd, 0);
    check("rst_par_rd", par_rd, 0);
    check("rst_done", done, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_din", din, 0);
    check("rst_sao", {sao_type, sao_band_pos, sao_eo_class, sao_offset}, 0);
    check("rst_lcu_xy_size", {lcu_x, lcu_y, lcu_size}, 0);
    check("rst_img_addr", img_addr, 0);
    check("rst_par_addr", par_addr, 0);
    tick();
    reset  = 1'b0;
    mon_en = 1'b1;

    // Reserved LCU size: error pulse, no memory traffic
    clear_counts();
    cfg_lcu_size = 2'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("cfg_err_pulse", cfg_err, 1);
    @(negedge clk);
    check("cfg_err_one_cycle", cfg_err, 0);
    repeat (4) @(negedge clk);
    check("cfg_err_no_img_rd", n_rd, 0);
    check("cfg_err_no_par_rd", n_par, 0);
    check("cfg_err_count", n_cfg_err, 1);

    // Frame A: 16x16 LCUs, no backpressure, stray start mid-frame
    rand_busy = 1'b0;
    start_frame(0);
    repeat (300) @(negedge clk);
    tick();
    cfg_lcu_size = 2'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    finish_frame(20000, 64);
    check("a_px255", cap_255, {8'hFF, 2'd1, 5'd3, 1'b0, 16'h0020, 3'd0, 3'd0, 2'd0});
    check("a_px256", cap_256, {8'h00, 2'd2, 5'd5, 1'b1, 16'h0003, 3'd1, 3'd0, 2'd0});
    check("a_last_din", cap_last[39:32], 8'hFF);
    check("a_last_xy", cap_last[7:2], {3'd7, 3'd7});

    // Frame B: 64x64 LCUs
    start_frame(2);
    check("b_lcu_size", lcu_size, 2);
    finish_frame(20000, 4);
    check("b_px4096", {cap_4096[39:32], cap_4096[7:0]}, {8'h00, 3'd1, 3'd0, 2'd2});
    check("b_px8192", cap_8192[7:0], {3'd0, 3'd1, 2'd2});
    check("b_last", {cap_last[39:32], cap_last[7:0]}, {8'hFF, 3'd1, 3'd1, 2'd2});

    // Frame C: 16x16 LCUs with random backpressure
    rand_busy = 1'b1;
    start_frame(0);
    finish_frame(60000, 64);
    check("c_px256", cap_256, {8'h00, 2'd2, 5'd5, 1'b1, 16'h0003, 3'd1, 3'd0, 2'd0});
    rand_busy = 1'b0;

    // Reset at beat 1000 abandons the frame; a fresh start begins at address 0
    start_frame(0);
    c = 0;
    while (n_beats < 1000 && c < 5000) begin
      @(negedge clk);
      c++;
    end
    check("reach_beat_1000", (n_beats >= 1000), 1);
    tick();
    reset  = 1'b1;
    mon_en = 1'b0;
    tick();
    reset  = 1'b0;
    @(negedge clk);
    check("mid_rst_in_en", in_en, 0);
    check("mid_rst_img_rd", img_rd, 0);
    check("mid_rst_img_addr", img_addr, 0);
    check("mid_rst_state", dbg_state, 0);
    check("mid_rst_sideband", {sao_type, sao_band_pos, sao_eo_class, sao_offset, lcu_x, lcu_y}, 0);
    @(negedge clk);
    check("mid_rst_discard", in_en, 0);
    mon_en = 1'b1;
    start_frame(0);
    repeat (600) @(negedge clk);
    check("restart_progress", (n_beats > 500), 1);
    mon_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no end of test, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
